// File: rtl/param_stream_pkg.sv
// Shared types for the parameter-ROM stream sequencer: FSM states, tag-pipe entry, default ROM latency.
package param_stream_pkg;

  localparam int ROM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/param_stream_fifo.sv
// Small synchronous FIFO with simultaneous push/pop and an occupancy count; head word reads as zero when empty.
module param_stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign rd_data_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/param_stream_ctrl.sv
// Credit-limited ROM read sequencer producing a valid/ready stream of OUT_DEPTH words per pass.
// rst is asynchronous active-low. Optional perf counters enabled by PARAM_STREAM_CTRL_PERF_EN.
module param_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_DEPTH   = 32,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 8,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
`ifdef PARAM_STREAM_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_words,
  output logic [31:0]           perf_stall
`endif
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);
  localparam logic [OCC_W-1:0]      OCC_MAX   = OCC_W'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d, passes_q, passes_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  tag_t                  tag_q [ROM_LATENCY];
  logic                  issue, pop, final_rd;
  logic [OCC_W-1:0]      fifo_count;

  assign pop      = data_out_valid & data_out_ready;
  assign final_rd = (pass_q == passes_q - PASS_WIDTH'(1)) && (addr_q == LAST_ADDR);
  // occ covers in-flight ROM reads too, so the FIFO always has room when a tag exits.
  assign issue    = (state_q == RUN) && ((occ_q - OCC_W'(pop)) < OCC_MAX);
  assign occ_d    = occ_q + OCC_W'(issue) - OCC_W'(pop);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          addr_d   = '0;
          pass_d   = '0;
          passes_d = (cfg_passes == '0) ? PASS_WIDTH'(1) : cfg_passes;
        end
      end
      RUN: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
          if (final_rd) state_d = DRAIN;
        end
      end
      DRAIN:   if (occ_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pass_q   <= '0;
      passes_q <= PASS_WIDTH'(1);
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      occ_q    <= occ_d;
    end
  end

  // Tag pipe mirrors the ROM read latency; non-issued cycles carry valid=0 and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {issue, issue && (addr_q == LAST_ADDR)};
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  param_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (tag_q[ROM_LATENCY-1].valid),
    .wr_data_i ({tag_q[ROM_LATENCY-1].last, rom_q}),
    .pop_i     (pop),
    .rd_data_o ({data_out_last, data_out}),
    .count_o   (fifo_count)
  );

  assign data_out_valid = (fifo_count != '0);
  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign rom_addr       = addr_q;
  assign rom_ce         = 1'b1;

`ifdef PARAM_STREAM_CTRL_PERF_EN
  logic [31:0] perf_words_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (pop && (perf_words_q != '1)) perf_words_q <= perf_words_q + 32'd1;
      if (data_out_valid && !data_out_ready && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_words = perf_words_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Scoreboard bench for param_stream_ctrl: two instances (OUT_DEPTH 4 and 32) fed by 2-cycle ROM models.
module tb_param_stream_ctrl;

  localparam int FIFO_D = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // shared stimulus, steered to one instance by sel
  int         sel;
  logic       start_m;
  logic [7:0] cfg_m;
  logic       rdy_m;

  logic        start_a, busy_a, done_a, ce_a, dv_a, dlast_a;
  logic [2:0]  addr_a;
  logic [31:0] romq_a, dout_a;
  logic        start_b, busy_b, done_b, ce_b, dv_b, dlast_b;
  logic [5:0]  addr_b;
  logic [31:0] romq_b, dout_b;

  logic [31:0] rom_mem [2][32];
  logic [31:0] q1_a, q1_b;

  assign start_a = start_m && (sel == 0);
  assign start_b = start_m && (sel == 1);

`ifdef PARAM_STREAM_CTRL_PERF_EN
  logic [31:0] pw_a, ps_a, pw_b, ps_b;
`endif

  param_stream_ctrl #(.OUT_DEPTH(4)) u_a (
    .clk(clk), .rst(rst_n), .start(start_a), .cfg_passes(cfg_m),
    .busy(busy_a), .done(done_a), .rom_addr(addr_a), .rom_ce(ce_a), .rom_q(romq_a),
    .data_out(dout_a), .data_out_valid(dv_a), .data_out_ready(rdy_m), .data_out_last(dlast_a)
`ifdef PARAM_STREAM_CTRL_PERF_EN
    , .perf_words(pw_a), .perf_stall(ps_a)
`endif
  );

  param_stream_ctrl #(.OUT_DEPTH(32)) u_b (
    .clk(clk), .rst(rst_n), .start(start_b), .cfg_passes(cfg_m),
    .busy(busy_b), .done(done_b), .rom_addr(addr_b), .rom_ce(ce_b), .rom_q(romq_b),
    .data_out(dout_b), .data_out_valid(dv_b), .data_out_ready(rdy_m), .data_out_last(dlast_b)
`ifdef PARAM_STREAM_CTRL_PERF_EN
    , .perf_words(pw_b), .perf_stall(ps_b)
`endif
  );

  // ROM models: registered address, two-cycle read pipeline
  always @(posedge clk) begin
    q1_a   <= rom_mem[0][addr_a];
    romq_a <= q1_a;
    q1_b   <= rom_mem[1][addr_b[4:0]];
    romq_b <= q1_b;
  end

  logic        busy_m, done_m, dv_m, dlast_m;
  logic [5:0]  addr_m;
  logic [31:0] dout_m;
  always_comb begin
    busy_m = busy_a; done_m = done_a; dv_m = dv_a; dlast_m = dlast_a;
    addr_m = {3'b000, addr_a}; dout_m = dout_a;
    if (sel == 1) begin
      busy_m = busy_b; done_m = done_b; dv_m = dv_b; dlast_m = dlast_b;
      addr_m = addr_b; dout_m = dout_b;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; sel = 0; start_m = 1'b0; cfg_m = 8'd0; rdy_m = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy_a, done_a, addr_a, ce_a, dv_a, dlast_a, dout_a} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_a got busy=%b done=%b addr=%0d ce=%b valid=%b last=%b data=%h need 0,0,0,1,0,0,0",
               busy_a, done_a, addr_a, ce_a, dv_a, dlast_a, dout_a);
    end
    total++;
    if ({busy_b, done_b, addr_b, ce_b, dv_b, dlast_b, dout_b} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_b got busy=%b done=%b addr=%0d ce=%b valid=%b last=%b data=%h need 0,0,0,1,0,0,0",
               busy_b, done_b, addr_b, ce_b, dv_b, dlast_b, dout_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: checked");
  endtask

  // mode 0: ready high; mode 1: ready low on cycles 2..lo_to; mode 2: random ready
  task automatic run_stream(input int d, input int cfg, input int mode, input int lo_to,
                            input int restart_cyc, input string name);
    logic [32:0] exp_q[$];
    logic [32:0] got, want;
    int dep, np, k, last_pop, base, cyc;
    logic rdy, exp_done, finished;
    dep = (d == 0) ? 4 : 32;
    np  = (cfg == 0) ? 1 : cfg;
    for (int p = 0; p < np; p++)
      for (int a = 0; a < dep; a++)
        exp_q.push_back({(a == dep - 1), rom_mem[d][a]});
    base = (lo_to + 1 > 4) ? lo_to + 1 : 4;
    k = 0; last_pop = -10; finished = 1'b0;
    @(negedge clk);
    sel = d; cfg_m = 8'(cfg); start_m = 1'b1; rdy_m = 1'b0;
    for (cyc = 1; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      start_m = (cyc == restart_cyc);
      if (cyc == restart_cyc) cfg_m = 8'd5;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc >= 2 && cyc <= lo_to);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rdy_m = rdy;
      #1;
      if (mode == 1 && cyc == lo_to) begin
        total++;
        if (addr_m !== 6'(FIFO_D % dep) || dv_m !== 1'b1) begin
          bad++;
          $display("FAIL %s stall_hold got addr=%0d valid=%b need addr=%0d valid=1",
                   name, addr_m, dv_m, FIFO_D % dep);
        end
      end
      exp_done = (exp_q.size() == 0) && (cyc == last_pop + 1);
      total++;
      if (done_m !== exp_done || busy_m !== !exp_done) begin
        bad++;
        $display("FAIL %s done_busy cyc=%0d got done=%b busy=%b need done=%b busy=%b",
                 name, cyc, done_m, busy_m, exp_done, !exp_done);
      end
      if (done_m === 1'b1 || exp_done) begin
        finished = 1'b1;
        $display("%s: done at cycle %0d", name, cyc);
      end
      if (dv_m === 1'b1 && rdy) begin
        got = {dlast_m, dout_m};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_word cyc=%0d got %h need none", name, cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL %s word%0d got last=%b data=%h need last=%b data=%h",
                     name, k, got[32], got[31:0], want[32], want[31:0]);
          end
        end
        if (mode != 2) begin
          total++;
          if (cyc != base + k) begin
            bad++;
            $display("FAIL %s word%0d_cycle got %0d need %0d", name, k, cyc, base + k);
          end
        end
        $display("%s: word %0d cyc %0d data=%h last=%b", name, k, cyc, dout_m, dlast_m);
        k++;
        last_pop = cyc;
      end
    end
    start_m = 1'b0;
    total++;
    if (!finished || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s completion got finished=%b left=%0d need finished=1 left=0",
               name, finished, exp_q.size());
    end
    rdy_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({busy_m, done_m, dv_m} !== 3'b000) begin
        bad++;
        $display("FAIL %s idle_after busy=%b done=%b valid=%b need 0,0,0", name, busy_m, done_m, dv_m);
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    sel = 0; cfg_m = 8'd1; start_m = 1'b1; rdy_m = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_m = 1'b0;
    end
    total++;
    if (dv_a !== 1'b1 || dout_a !== rom_mem[0][1]) begin
      bad++;
      $display("FAIL midrun_pre got valid=%b data=%h need valid=1 data=%h", dv_a, dout_a, rom_mem[0][1]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy_a, done_a, addr_a, ce_a, dv_a, dlast_a, dout_a} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL midrun_reset got busy=%b done=%b addr=%0d ce=%b valid=%b last=%b data=%h need 0,0,0,1,0,0,0",
               busy_a, done_a, addr_a, ce_a, dv_a, dlast_a, dout_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({busy_a, done_a, dv_a} !== 3'b000) begin
        bad++;
        $display("FAIL midrun_quiet busy=%b done=%b valid=%b need 0,0,0", busy_a, done_a, dv_a);
      end
    end
    $display("midrun_reset: checked");
  endtask

  initial begin
    for (int a = 0; a < 32; a++) begin
      rom_mem[0][a] = 32'(a);
      rom_mem[1][a] = $urandom;
    end
    test_reset();
    run_stream(0, 1, 0, -1, -1, "single_pass");
    run_stream(0, 3, 0, -1, -1, "three_pass");
    run_stream(0, 3, 1, 20, -1, "ready_stall");
    run_stream(1, 2, 2, -1, -1, "random_ready");
    run_stream(0, 2, 0, -1, 3, "start_ignored");
    run_stream(0, 0, 0, -1, -1, "zero_passes");
    test_reset_midrun();
    run_stream(0, 1, 0, -1, -1, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
